// File: rtl/ysyx_24100005_mem_responder.sv
// Memory-side responder for LSU loads/stores: word storage, programmable response latency,
// valid/ready on both channels, backed by an internal register array.
module ysyx_24100005_mem_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        wen_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wmask_reg;
    logic        in_range_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;

    logic        accept;
    logic        do_access;
    logic        in_range;

    // Access operands: straight from the request when the access lands on the accept edge
    // (single-cycle latency), otherwise from the holding registers.
    logic        acc_from_req;
    logic        acc_wen;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_wmask;
    logic        acc_in_range;

    assign accept       = req_valid && req_ready;
    assign acc_from_req = (state_reg == IDLE);
    assign acc_wen      = acc_from_req ? req_wen   : wen_reg;
    assign acc_wdata    = acc_from_req ? req_wdata : wdata_reg;
    assign acc_wmask    = acc_from_req ? req_wmask : wmask_reg;
    assign acc_in_range = acc_from_req ? in_range  : in_range_reg;

    logic [31:0]      offset;
    logic [IDX_W-1:0] idx_reg;
    logic [IDX_W-1:0] acc_idx;
    logic [31:0]      rd_word;
    logic             mem_we;
    logic             unused_offset_bits;

    // Wrapping subtract: addresses below BASE_ADDR land far above DEPTH and read as out of range.
    assign offset             = req_addr - BASE_ADDR;
    assign in_range           = (offset[31:2] < 30'(DEPTH));
    assign acc_idx            = acc_from_req ? offset[IDX_W+1:2] : idx_reg;
    assign mem_we             = do_access && acc_wen && acc_in_range && !rst;
    assign unused_offset_bits = ^offset[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg <= '0;
        end else if (accept) begin
            idx_reg <= offset[IDX_W+1:2];
        end
    end

    // One byte-wide array per lane so the write mask maps onto independent lane enables.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem_lane [DEPTH];

        always_ff @(posedge clk) begin
            if (mem_we && acc_wmask[gi]) begin
                mem_lane[acc_idx] <= acc_wdata[8*gi +: 8];
            end
        end

        assign rd_word[8*gi +: 8] = mem_lane[acc_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            wen_reg      <= 1'b0;
            wdata_reg    <= '0;
            wmask_reg    <= '0;
            in_range_reg <= 1'b0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                wen_reg      <= req_wen;
                wdata_reg    <= req_wdata;
                wmask_reg    <= req_wmask;
                in_range_reg <= in_range;
            end
            if (do_access) begin
                err_reg   <= !acc_in_range;
                rdata_reg <= (!acc_wen && acc_in_range) ? rd_word : '0;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        do_access  = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        do_access  = 1'b1;
                        state_next = RESP;
                    end else begin
                        cnt_next   = 4'(LATENCY - 2);
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    do_access  = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rsp_rdata = rdata_reg;
    assign rsp_err   = err_reg;

endmodule

// File: tb/tb_ysyx_24100005_mem_responder.sv
// Bench for ysyx_24100005_mem_responder: one instance at LATENCY 2, one at LATENCY 4, selected by sel;
// table-driven transactions plus backpressure and reset-in-WAIT sequences, checked via a scoreboard queue.
module tb_ysyx_24100005_mem_responder;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req_valid, req_wen, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wmask;

    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;
    exp_t sb[$];
    vec_t tbl[15];

    always #5 clk = ~clk;

    ysyx_24100005_mem_responder #(.LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready & ~sel),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    ysyx_24100005_mem_responder #(.LATENCY(4)) u_dut_l4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & sel), .req_ready(b_req_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready & sel),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    assign req_ready = sel ? b_req_ready : a_req_ready;
    assign rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
    assign rsp_err   = sel ? b_rsp_err   : a_rsp_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic issue_req(input vec_t v, input bit expect_rsp);
        int guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("req_ready_timeout", 32'(req_ready), 32'd1);
        req_wen   = v.wen;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_wmask = v.mask;
        req_valid = 1'b1;
        if (expect_rsp) sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        // Request inputs are don't-care once accepted.
        req_wen   = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wmask = 4'($urandom);
    endtask

    // Latency is counted in cycles from the accept cycle, i.e. including the accept edge.
    task automatic collect_rsp(input vec_t v, input int hold);
        int          lat = 1;
        int          exp_lat;
        logic [31:0] snap_rdata;
        logic        snap_err;
        exp_t        e;
        exp_lat = sel ? 4 : 2;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        snap_rdata = rsp_rdata;
        snap_err   = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (i == 1) begin
                req_wen = 1'b1; req_addr = 32'h8000_0010; req_wdata = 32'h0; req_wmask = 4'hF;
                req_valid = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rdata", rsp_rdata, snap_rdata);
            chk("bp_err", 32'(rsp_err), 32'(snap_err));
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        $display("txn %0d: dut=L%0d %s addr=%h wdata=%h mask=%h -> rdata=%h err=%b lat=%0d",
                 n_txn, exp_lat, v.wen ? "WR" : "RD", v.addr, v.wdata, v.mask, rsp_rdata, rsp_err, lat);
        n_txn++;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("post_hs_valid", 32'(rsp_valid), 32'd0);
        chk("post_hs_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic run_txn(input vec_t v, input int hold);
        issue_req(v, 1'b1);
        collect_rsp(v, hold);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        int   seen;

        //         wen   addr           wdata          mask   exp_rdata      err
        tbl[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
        tbl[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 32'h0,         1'b0};
        tbl[3]  = '{1'b1, 32'h8000_0020, 32'h0000_AB00, 4'h2, 32'h0,         1'b0};
        tbl[4]  = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 32'h1122_AB44, 1'b0};
        tbl[5]  = '{1'b1, 32'h8000_0020, 32'h5566_0000, 4'hC, 32'h0,         1'b0};
        tbl[6]  = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 32'h5566_AB44, 1'b0};
        tbl[7]  = '{1'b1, 32'h8000_0FFC, 32'h0A0B_0C0D, 4'hF, 32'h0,         1'b0};
        tbl[8]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0,         1'b1};
        tbl[9]  = '{1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
        tbl[10] = '{1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 32'h0A0B_0C0D, 1'b0};
        tbl[11] = '{1'b1, 32'h8000_0040, 32'h1234_5678, 4'hF, 32'h0,         1'b0};
        tbl[12] = '{1'b1, 32'h8000_0040, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0};
        tbl[13] = '{1'b0, 32'h8000_0043, 32'h0,         4'h0, 32'h1234_5678, 1'b0};
        tbl[14] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0,         1'b1};

        rst = 1'b1; sel = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_l2_req_ready", 32'(a_req_ready), 32'd1);
        chk("rst_l2_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rst_l2_rsp_err",   32'(a_rsp_err),   32'd0);
        chk("rst_l2_rsp_rdata", a_rsp_rdata,      32'd0);
        chk("rst_l4_req_ready", 32'(b_req_ready), 32'd1);
        chk("rst_l4_rsp_valid", 32'(b_rsp_valid), 32'd0);
        chk("rst_l4_rsp_err",   32'(b_rsp_err),   32'd0);
        chk("rst_l4_rsp_rdata", b_rsp_rdata,      32'd0);

        for (int i = 0; i < 15; i++) run_txn(tbl[i], 0);

        // Backpressure: 5 stalled cycles with a write pulsed into the window; it must be ignored.
        v = '{1'b0, 32'h8000_0020, 32'h0, 4'h0, 32'h5566_AB44, 1'b0};
        run_txn(v, 5);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("bp_no_extra_rsp", 32'(seen), 32'd0);
        v = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0};
        run_txn(v, 0);

        // LATENCY 4 instance: seed a word, then reset in WAIT during an overwrite of it.
        sel = 1'b1;
        v = '{1'b1, 32'h8000_0030, 32'h0102_0304, 4'hF, 32'h0, 1'b0};
        run_txn(v, 0);
        v = '{1'b0, 32'h8000_0030, 32'h0, 4'h0, 32'h0102_0304, 1'b0};
        run_txn(v, 0);

        v = '{1'b1, 32'h8000_0030, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0};
        issue_req(v, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstwait_valid_in_rst", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstwait_req_ready", 32'(req_ready), 32'd1);
        chk("rstwait_rsp_valid", 32'(rsp_valid), 32'd0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("rstwait_no_rsp", 32'(seen), 32'd0);
        v = '{1'b0, 32'h8000_0030, 32'h0, 4'h0, 32'h0102_0304, 1'b0};
        run_txn(v, 0);
        v = '{1'b0, 32'h8000_1000, 32'h0, 4'h0, 32'h0, 1'b1};
        run_txn(v, 0);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
